// File: rtl/machine_csr_trap_unit.sv
// ============================================================================
// Module   : machine_csr_trap_unit
// Brief    : RV32 machine-mode CSR file and trap/MRET sequencer with PC redirect.
//            Optional counters (mcycle/minstret) built when ZICNTR_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module machine_csr_trap_unit #(
    parameter logic [31:0] MTVEC_RESET = 32'h0000_0000,
    parameter int unsigned HART_ID     = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [11:0] csr_addr,
    input  logic [1:0]  csr_op,
    input  logic [31:0] csr_wdata,
    output logic [31:0] csr_rdata,
    output logic        csr_illegal,
    input  logic        trap_valid,
    input  logic        trap_is_irq,
    input  logic [3:0]  trap_code,
    input  logic [31:0] trap_pc,
    input  logic [31:0] trap_tval,
    input  logic        mret_valid,
    input  logic        instr_retire,
    input  logic        irq_external,
    input  logic        irq_timer,
    output logic        irq_req,
    output logic [3:0]  irq_code,
    output logic        busy,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_TRAP = 2'd1;
    localparam logic [1:0] S_RET  = 2'd2;

    localparam logic [11:0] CSR_MSTATUS  = 12'h300;
    localparam logic [11:0] CSR_MIE      = 12'h304;
    localparam logic [11:0] CSR_MTVEC    = 12'h305;
    localparam logic [11:0] CSR_MSCRATCH = 12'h340;
    localparam logic [11:0] CSR_MEPC     = 12'h341;
    localparam logic [11:0] CSR_MCAUSE   = 12'h342;
    localparam logic [11:0] CSR_MTVAL    = 12'h343;
    localparam logic [11:0] CSR_MIP      = 12'h344;
    localparam logic [11:0] CSR_MHARTID  = 12'hF14;
`ifdef ZICNTR_EN
    localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
    localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
    localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
    localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
`endif

    logic [1:0]  state_q, state_d;
    logic        mstatus_mie_q, mstatus_mie_d;
    logic        mstatus_mpie_q, mstatus_mpie_d;
    logic        mie_mtie_q, mie_mtie_d;
    logic        mie_meie_q, mie_meie_d;
    logic [31:0] mtvec_q, mtvec_d;
    logic [31:0] mscratch_q, mscratch_d;
    logic [31:0] mepc_q, mepc_d;
    logic [31:0] mcause_q, mcause_d;
    logic [31:0] mtval_q, mtval_d;

    logic        csr_known;
    logic        csr_readonly;
    logic        csr_we;
    logic [31:0] csr_wval;
    logic [31:0] mtvec_base;

`ifdef ZICNTR_EN
    logic [63:0] mcycle_q, mcycle_d;
    logic [63:0] minstret_q, minstret_d;
`else
    logic        unused_retire;
    assign unused_retire = instr_retire;
`endif

    // Read mux: returns the pre-write value of the addressed CSR.
    always_comb begin
        csr_rdata    = 32'h0;
        csr_known    = 1'b1;
        csr_readonly = 1'b0;
        case (csr_addr)
            CSR_MSTATUS:  csr_rdata = {19'h0, 2'b11, 3'h0, mstatus_mpie_q, 3'h0, mstatus_mie_q, 3'h0};
            CSR_MIE:      csr_rdata = {20'h0, mie_meie_q, 3'h0, mie_mtie_q, 7'h0};
            CSR_MTVEC:    csr_rdata = mtvec_q;
            CSR_MSCRATCH: csr_rdata = mscratch_q;
            CSR_MEPC:     csr_rdata = mepc_q;
            CSR_MCAUSE:   csr_rdata = mcause_q;
            CSR_MTVAL:    csr_rdata = mtval_q;
            CSR_MIP: begin
                csr_rdata    = {20'h0, irq_external, 3'h0, irq_timer, 7'h0};
                csr_readonly = 1'b1;
            end
            CSR_MHARTID: begin
                csr_rdata    = 32'(HART_ID);
                csr_readonly = 1'b1;
            end
`ifdef ZICNTR_EN
            CSR_MCYCLE:    csr_rdata = mcycle_q[31:0];
            CSR_MCYCLEH:   csr_rdata = mcycle_q[63:32];
            CSR_MINSTRET:  csr_rdata = minstret_q[31:0];
            CSR_MINSTRETH: csr_rdata = minstret_q[63:32];
`endif
            default:      csr_known = 1'b0;
        endcase
    end

    assign csr_illegal = (csr_op != 2'b00) && (!csr_known || csr_readonly);
    // A trap accepted on the same edge takes precedence over a CSR write.
    assign csr_we = (csr_op != 2'b00) && !csr_illegal && (state_q == S_IDLE) && !trap_valid;

    always_comb begin
        case (csr_op)
            2'b10:   csr_wval = csr_rdata | csr_wdata;
            2'b11:   csr_wval = csr_rdata & ~csr_wdata;
            default: csr_wval = csr_wdata;
        endcase
    end

    always_comb begin
        state_d        = state_q;
        mstatus_mie_d  = mstatus_mie_q;
        mstatus_mpie_d = mstatus_mpie_q;
        mie_mtie_d     = mie_mtie_q;
        mie_meie_d     = mie_meie_q;
        mtvec_d        = mtvec_q;
        mscratch_d     = mscratch_q;
        mepc_d         = mepc_q;
        mcause_d       = mcause_q;
        mtval_d        = mtval_q;

        if (csr_we) begin
            case (csr_addr)
                CSR_MSTATUS: begin
                    mstatus_mie_d  = csr_wval[3];
                    mstatus_mpie_d = csr_wval[7];
                end
                CSR_MIE: begin
                    mie_mtie_d = csr_wval[7];
                    mie_meie_d = csr_wval[11];
                end
                // Reserved MODE encodings (1x) leave the current mode in place.
                CSR_MTVEC:    mtvec_d = {csr_wval[31:2], csr_wval[1] ? mtvec_q[1:0] : csr_wval[1:0]};
                CSR_MSCRATCH: mscratch_d = csr_wval;
                CSR_MEPC:     mepc_d = csr_wval & ~32'h3;
                CSR_MCAUSE:   mcause_d = csr_wval;
                CSR_MTVAL:    mtval_d = csr_wval;
                default: ;
            endcase
        end

        case (state_q)
            S_IDLE: begin
                if (trap_valid) begin
                    state_d        = S_TRAP;
                    mepc_d         = trap_pc & ~32'h3;
                    mcause_d       = {trap_is_irq, 27'h0, trap_code};
                    mtval_d        = trap_tval;
                    mstatus_mpie_d = mstatus_mie_q;
                    mstatus_mie_d  = 1'b0;
                end else if (mret_valid) begin
                    state_d        = S_RET;
                    mstatus_mie_d  = mstatus_mpie_q;
                    mstatus_mpie_d = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= S_IDLE;
            mstatus_mie_q  <= 1'b0;
            mstatus_mpie_q <= 1'b0;
            mie_mtie_q     <= 1'b0;
            mie_meie_q     <= 1'b0;
            mtvec_q        <= MTVEC_RESET;
            mscratch_q     <= 32'h0;
            mepc_q         <= 32'h0;
            mcause_q       <= 32'h0;
            mtval_q        <= 32'h0;
        end else begin
            state_q        <= state_d;
            mstatus_mie_q  <= mstatus_mie_d;
            mstatus_mpie_q <= mstatus_mpie_d;
            mie_mtie_q     <= mie_mtie_d;
            mie_meie_q     <= mie_meie_d;
            mtvec_q        <= mtvec_d;
            mscratch_q     <= mscratch_d;
            mepc_q         <= mepc_d;
            mcause_q       <= mcause_d;
            mtval_q        <= mtval_d;
        end
    end

`ifdef ZICNTR_EN
    // Counter writes override the increment; a half-write leaves the other half as is.
    always_comb begin
        mcycle_d = mcycle_q + 64'd1;
        if (csr_we && csr_addr == CSR_MCYCLE) begin
            mcycle_d = {mcycle_q[63:32], csr_wval};
        end else if (csr_we && csr_addr == CSR_MCYCLEH) begin
            mcycle_d = {csr_wval, mcycle_q[31:0]};
        end

        minstret_d = minstret_q;
        if (csr_we && csr_addr == CSR_MINSTRET) begin
            minstret_d = {minstret_q[63:32], csr_wval};
        end else if (csr_we && csr_addr == CSR_MINSTRETH) begin
            minstret_d = {csr_wval, minstret_q[31:0]};
        end else if (instr_retire) begin
            minstret_d = minstret_q + 64'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcycle_q   <= 64'h0;
            minstret_q <= 64'h0;
        end else begin
            mcycle_q   <= mcycle_d;
            minstret_q <= minstret_d;
        end
    end
`endif

    assign busy       = (state_q != S_IDLE);
    assign irq_req    = mstatus_mie_q && ((mie_meie_q && irq_external) || (mie_mtie_q && irq_timer)) && !busy;
    assign irq_code   = (mie_meie_q && irq_external) ? 4'd11 : 4'd7;
    assign mtvec_base = {mtvec_q[31:2], 2'b00};

    always_comb begin
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        case (state_q)
            S_TRAP: begin
                redirect_valid = 1'b1;
                if (mtvec_q[1:0] == 2'b01 && mcause_q[31]) begin
                    redirect_pc = mtvec_base + {26'h0, mcause_q[3:0], 2'b00};
                end else begin
                    redirect_pc = mtvec_base;
                end
            end
            S_RET: begin
                redirect_valid = 1'b1;
                redirect_pc    = mepc_q;
            end
            default: ;
        endcase
    end

endmodule

`default_nettype wire

// File: tb/tb_machine_csr_trap_unit.sv
// ============================================================================
// Module   : tb_machine_csr_trap_unit
// Brief    : Directed plus randomized checks of machine_csr_trap_unit against a
//            behavioural CSR/trap model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_machine_csr_trap_unit;

    localparam logic [31:0] MTVEC_RST = 32'h0000_1001;
    localparam int unsigned HARTID    = 3;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [11:0] csr_addr;
    logic [1:0]  csr_op;
    logic [31:0] csr_wdata;
    logic [31:0] csr_rdata;
    logic        csr_illegal;
    logic        trap_valid;
    logic        trap_is_irq;
    logic [3:0]  trap_code;
    logic [31:0] trap_pc;
    logic [31:0] trap_tval;
    logic        mret_valid;
    logic        instr_retire;
    logic        irq_external;
    logic        irq_timer;
    logic        irq_req;
    logic [3:0]  irq_code;
    logic        busy;
    logic        redirect_valid;
    logic [31:0] redirect_pc;

    int n_cmp = 0;
    int n_err = 0;

    // Behavioural model of the architectural CSR state.
    logic        m_mie, m_mpie, m_mtie, m_meie;
    logic [31:0] m_mtvec, m_mscratch, m_mepc, m_mcause, m_mtval;

    machine_csr_trap_unit #(
        .MTVEC_RESET (MTVEC_RST),
        .HART_ID     (HARTID)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .csr_addr       (csr_addr),
        .csr_op         (csr_op),
        .csr_wdata      (csr_wdata),
        .csr_rdata      (csr_rdata),
        .csr_illegal    (csr_illegal),
        .trap_valid     (trap_valid),
        .trap_is_irq    (trap_is_irq),
        .trap_code      (trap_code),
        .trap_pc        (trap_pc),
        .trap_tval      (trap_tval),
        .mret_valid     (mret_valid),
        .instr_retire   (instr_retire),
        .irq_external   (irq_external),
        .irq_timer      (irq_timer),
        .irq_req        (irq_req),
        .irq_code       (irq_code),
        .busy           (busy),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_mie = 0; m_mpie = 0; m_mtie = 0; m_meie = 0;
        m_mtvec = MTVEC_RST; m_mscratch = 0; m_mepc = 0; m_mcause = 0; m_mtval = 0;
    endtask

    function automatic logic writable(input logic [11:0] a);
        return a inside {12'h300, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342, 12'h343};
    endfunction

    function automatic logic [31:0] mread(input logic [11:0] a);
        case (a)
            12'h300: return 32'h1800 | (32'(m_mpie) << 7) | (32'(m_mie) << 3);
            12'h304: return (32'(m_meie) << 11) | (32'(m_mtie) << 7);
            12'h305: return m_mtvec;
            12'h340: return m_mscratch;
            12'h341: return m_mepc;
            12'h342: return m_mcause;
            12'h343: return m_mtval;
            12'h344: return (32'(irq_external) << 11) | (32'(irq_timer) << 7);
            12'hF14: return 32'(HARTID);
            default: return 32'h0;
        endcase
    endfunction

    task automatic mwrite(input logic [11:0] a, input logic [31:0] v);
        case (a)
            12'h300: begin m_mie = v[3]; m_mpie = v[7]; end
            12'h304: begin m_mtie = v[7]; m_meie = v[11]; end
            12'h305: if (v[1] == 1'b0) m_mtvec = v; else m_mtvec = {v[31:2], m_mtvec[1:0]};
            12'h340: m_mscratch = v;
            12'h341: m_mepc = v & ~32'h3;
            12'h342: m_mcause = v;
            12'h343: m_mtval = v;
            default: ;
        endcase
    endtask

    task automatic idle_inputs();
        csr_op = 0; csr_addr = 0; csr_wdata = 0; trap_valid = 0; trap_is_irq = 0;
        trap_code = 0; trap_pc = 0; trap_tval = 0; mret_valid = 0;
    endtask

    task automatic peek(input string tag, input logic [11:0] a, input logic [31:0] exp);
        idle_inputs();
        csr_addr = a;
        @(negedge clk);
        chk(tag, csr_rdata, exp);
    endtask

    // One request cycle in IDLE, followed by the redirect cycle when a trap/MRET is issued.
    task automatic do_cycle(input logic [1:0] op, input logic [11:0] a, input logic [31:0] wd,
                            input logic tv, input logic irq, input logic [3:0] code,
                            input logic [31:0] pc, input logic [31:0] tval, input logic mr);
        logic [31:0] old_v, new_v, exp_pc, base;
        logic        wr, pend_ext, pend_tim;
        csr_op = op; csr_addr = a; csr_wdata = wd; trap_valid = tv; trap_is_irq = irq;
        trap_code = code; trap_pc = pc; trap_tval = tval; mret_valid = mr;
        #3;
        pend_ext = m_meie && irq_external;
        pend_tim = m_mtie && irq_timer;
        chk("busy_idle", 32'(busy), 32'd0);
        chk("redirect_idle", 32'(redirect_valid), 32'd0);
        chk("rdata", csr_rdata, mread(a));
        chk("illegal", 32'(csr_illegal), 32'((op != 0) && !writable(a)));
        chk("irq_req", 32'(irq_req), 32'(m_mie && (pend_ext || pend_tim)));
        chk("irq_code", 32'(irq_code), pend_ext ? 32'd11 : 32'd7);
        old_v = mread(a);
        wr = (op != 0) && writable(a) && !tv;
        case (op)
            2'd2:    new_v = old_v | wd;
            2'd3:    new_v = old_v & ~wd;
            default: new_v = wd;
        endcase
        tick();
        if (wr) mwrite(a, new_v);
        exp_pc = 0;
        if (tv) begin
            m_mepc = pc & ~32'h3;
            m_mcause = {irq, 27'h0, code};
            m_mtval = tval;
            m_mpie = m_mie;
            m_mie = 0;
            base = m_mtvec & ~32'h3;
            exp_pc = (m_mtvec[1:0] == 2'b01 && irq) ? base + 32'(code) * 4 : base;
        end else if (mr) begin
            m_mie = m_mpie;
            m_mpie = 1;
            exp_pc = m_mepc;
        end
        if (tv || mr) begin
            // Requests presented while the sequencer is busy must have no effect.
            trap_valid = 1'($urandom); mret_valid = 1'($urandom); trap_pc = $urandom;
            trap_tval = $urandom; trap_code = 4'($urandom);
            csr_op = 2'd1; csr_addr = 12'h340; csr_wdata = $urandom;
            #3;
            chk("redirect_valid", 32'(redirect_valid), 32'd1);
            chk("busy", 32'(busy), 32'd1);
            chk("redirect_pc", redirect_pc, exp_pc);
            chk("irq_req_busy", 32'(irq_req), 32'd0);
            tick();
            idle_inputs();
            #1;
            chk("redirect_drop", 32'(redirect_valid), 32'd0);
            chk("busy_drop", 32'(busy), 32'd0);
        end
    endtask

    logic [11:0] addr_pool [12] = '{12'h300, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342,
                                    12'h343, 12'h344, 12'hF14, 12'h7C0, 12'h300, 12'h304};

    initial begin
        logic [1:0]  op;
        logic        tv, mr;
        idle_inputs();
        instr_retire = 0; irq_external = 0; irq_timer = 0;
        rst_n = 0;
        model_reset();
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_redirect", 32'(redirect_valid), 32'd0);
        chk("rst_redirect_pc", redirect_pc, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1;
        peek("rst_mtvec", 12'h305, MTVEC_RST);
        peek("rst_mstatus", 12'h300, 32'h0000_1800);

        // Vectored external interrupt.
        irq_external = 1;
        do_cycle(2'd1, 12'h305, 32'h8000_0001, 0, 0, 0, 0, 0, 0);
        do_cycle(2'd2, 12'h300, 32'h0000_0008, 0, 0, 0, 0, 0, 0);
        do_cycle(2'd1, 12'h304, 32'h0000_0800, 0, 0, 0, 0, 0, 0);
        idle_inputs();
        @(negedge clk);
        chk("tp_irq_req", 32'(irq_req), 32'd1);
        chk("tp_irq_code", 32'(irq_code), 32'd11);
        do_cycle(2'd0, 12'h300, 0, 1, 1, 4'd11, 32'h100, 32'h0, 0);
        peek("tp_mepc", 12'h341, 32'h0000_0100);
        peek("tp_mcause", 12'h342, 32'h8000_000B);
        peek("tp_mstatus_trap", 12'h300, 32'h0000_1880);
        do_cycle(2'd0, 12'h300, 0, 0, 0, 0, 0, 0, 1);
        peek("tp_mstatus_mret", 12'h300, 32'h0000_1888);

        // Synchronous exception, then MRET back to the aligned PC.
        irq_external = 0;
        do_cycle(2'd0, 12'h300, 0, 1, 0, 4'd2, 32'h203, 32'hDEAD_BEEF, 0);
        peek("exc_mepc", 12'h341, 32'h0000_0200);
        peek("exc_mtval", 12'h343, 32'hDEAD_BEEF);
        do_cycle(2'd0, 12'h341, 0, 0, 0, 0, 0, 0, 1);

        // Trap + MRET + CSR write together: only the trap happens.
        do_cycle(2'd1, 12'h340, 32'h0000_1234, 0, 0, 0, 0, 0, 0);
        do_cycle(2'd1, 12'h340, 32'h5555_5555, 1, 0, 4'd3, 32'h400, 32'h0, 1);
        peek("collide_mscratch", 12'h340, 32'h0000_1234);

        // Set/clear of MIE, read-only and unimplemented accesses, reserved mtvec mode.
        do_cycle(2'd3, 12'h300, 32'h0000_0008, 0, 0, 0, 0, 0, 0);
        peek("clear_mie", 12'h300, 32'h0000_1880);
        do_cycle(2'd2, 12'h300, 32'h0000_0008, 0, 0, 0, 0, 0, 0);
        peek("set_mie", 12'h300, 32'h0000_1888);
        irq_timer = 1;
        do_cycle(2'd1, 12'h344, 32'h0000_0000, 0, 0, 0, 0, 0, 0);
        peek("mip_ro", 12'h344, 32'h0000_0080);
        peek("mhartid", 12'hF14, 32'd3);
        do_cycle(2'd1, 12'hF14, 32'h0000_0007, 0, 0, 0, 0, 0, 0);
        do_cycle(2'd1, 12'h305, 32'h4000_0002, 0, 0, 0, 0, 0, 0);
        peek("mtvec_keep_mode", 12'h305, 32'h4000_0001);
        do_cycle(2'd1, 12'h7C0, 32'h1, 0, 0, 0, 0, 0, 0);
`ifndef ZICNTR_EN
        do_cycle(2'd1, 12'hB00, 32'h1, 0, 0, 0, 0, 0, 0);
        do_cycle(2'd2, 12'hB82, 32'h1, 0, 0, 0, 0, 0, 0);
`else
        idle_inputs();
        @(negedge clk);
        csr_op = 2'd1; csr_addr = 12'hB00; csr_wdata = 32'hFFFF_FFFF;
        #1;
        chk("mcycle_legal", 32'(csr_illegal), 32'd0);
        tick();
        csr_op = 2'd0;
        #1;
        chk("mcycle_written", csr_rdata, 32'hFFFF_FFFF);
        tick();
        chk("mcycle_wrap", csr_rdata, 32'h0);
        csr_addr = 12'hB80;
        #1;
        chk("mcycleh_carry", csr_rdata, 32'h1);
        csr_op = 2'd1; csr_addr = 12'hB02; csr_wdata = 32'h5; instr_retire = 1;
        tick();
        csr_op = 2'd0;
        #1;
        chk("minstret_write_wins", csr_rdata, 32'h5);
        tick();
        chk("minstret_inc", csr_rdata, 32'h6);
        instr_retire = 0;
        idle_inputs();
`endif

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            irq_external = 1'($urandom);
            irq_timer    = 1'($urandom);
            instr_retire = 1'($urandom);
            op = 2'($urandom);
            tv = ($urandom_range(0, 5) == 0);
            mr = ($urandom_range(0, 5) == 0);
            if (mr && !tv) op = 2'd0;
            do_cycle(op, addr_pool[$urandom_range(0, 11)], $urandom, tv, 1'($urandom),
                     4'($urandom), $urandom, $urandom, mr);
        end

        // Reset while a redirect is pending: no redirect, state back to reset values.
        do_cycle(2'd2, 12'h300, 32'h0000_0008, 0, 0, 0, 0, 0, 0);
        trap_valid = 1; trap_pc = 32'h0000_0800;
        tick();
        idle_inputs();
        #2;
        rst_n = 0;
        #1;
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_redirect", 32'(redirect_valid), 32'd0);
        chk("midrst_mepc_clear", dut.mepc_q, 32'h0);
        #3;
        rst_n = 1;
        model_reset();
        peek("midrst_mstatus", 12'h300, 32'h0000_1800);
        peek("midrst_mtvec", 12'h305, MTVEC_RST);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire

// File: doc/machine_csr_trap_unit.md
Name: machine_csr_trap_unit

Overview:
- Machine-mode CSR file and trap sequencer for the RV32 core, directly downstream of the exception handler.
- Consumes its decoded trap/mret requests, updates mstatus/mepc/mcause/mtval, and produces a one-cycle PC redirect to the fetch stage.
- Also serves Zicsr read/write accesses from execute and generates the qualified interrupt request fed back to the exception handler.

Parameters:
- MTVEC_RESET, 32'h0000_0000, reset value of mtvec (BASE and MODE fields).
- HART_ID, 0, value returned by mhartid (0xF14).

Ports:
- clk  in  1  core clock.
- rst_n  in  1  asynchronous active-low reset.
- csr_addr  in  12  CSR address.
- csr_op  in  2  00 none, 01 write, 10 set, 11 clear.
- csr_wdata  in  32  write/set/clear operand.
- csr_rdata  out  32  combinational read data for csr_addr (old value).
- csr_illegal  out  1  combinational: csr_op!=0 and (unimplemented address, or write to read-only address).
- trap_valid  in  1  trap request, single-cycle pulse.
- trap_is_irq  in  1  1 = interrupt, 0 = exception.
- trap_code  in  4  cause code.
- trap_pc  in  32  PC of faulting/interrupted instruction.
- trap_tval  in  32  mtval value.
- mret_valid  in  1  MRET request pulse.
- instr_retire  in  1  one instruction retired this cycle.
- irq_external  in  1  level MEIP source.
- irq_timer  in  1  level MTIP source.
- irq_req  out  1  interrupt enabled and pending.
- irq_code  out  4  11 (external) or 7 (timer).
- busy  out  1  sequencer not IDLE; upstream holds requests.
- redirect_valid  out  1  single-cycle PC redirect strobe.
- redirect_pc  out  32  redirect target.

Behaviour:
- Reset (async, rst_n low), all registers cleared except:
  - mstatus: MIE=0, MPIE=0; MPP hardwired 2'b11.
  - mtvec = MTVEC_RESET.
  - state = IDLE.
  - Outputs: redirect_valid=0, busy=0, redirect_pc=0.
- Implemented CSRs:
  - mstatus 0x300: MIE bit3, MPIE bit7, MPP 12:11 read 11; other bits read 0.
  - mie 0x304: MTIE bit7, MEIE bit11.
  - mtvec 0x305: MODE 1:0, values 00/01 only; writes of 1x keep the old MODE.
  - mscratch 0x340.
  - mepc 0x341: bits 1:0 forced 0.
  - mcause 0x342.
  - mtval 0x343.
- Read-only CSRs:
  - mip 0x344: MTIP bit7 = irq_timer, MEIP bit11 = irq_external.
  - mhartid 0xF14.
- CSR writes:
  - Take effect at the clock edge when csr_op!=0, csr_illegal=0 and state=IDLE.
  - Set computes old|wdata; clear computes old&~wdata.
  - Writes while busy are dropped; upstream must not issue them.
- irq_req = MIE & ((MEIE&MEIP)|(MTIE&MTIP)), forced 0 while busy.
- irq_code = 11 if external is enabled and pending, else 7.
- FSM states: IDLE, TRAP, RET.
  - IDLE, trap_valid=1 → TRAP. Same edge:
    - mepc ← trap_pc & ~3.
    - mcause ← {trap_is_irq, 27'b0, trap_code}.
    - mtval ← trap_tval.
    - MPIE ← MIE, MIE ← 0.
  - IDLE, mret_valid=1 (trap_valid=0) → RET. Same edge: MIE ← MPIE, MPIE ← 1.
  - TRAP → IDLE. redirect_valid=1 for exactly this cycle. redirect_pc:
    - direct mode: mtvec.BASE.
    - vectored mode with irq: BASE + 4*code.
    - vectored mode with exception: BASE.
  - RET → IDLE. redirect_valid=1, redirect_pc = mepc.
- busy = (state != IDLE). Latency from request to redirect is 1 cycle.
- Simultaneous events:
  - trap_valid and mret_valid together: trap wins, mret is ignored.
  - trap_valid with a CSR write in the same cycle: trap wins, CSR write dropped.
  - Requests arriving in TRAP or RET are ignored.
- Reset mid-sequence: returns to IDLE immediately, no redirect issued.
- redirect_pc arithmetic is 32-bit, wrap-around ignored.

Optional Feature:
- ZICNTR_EN defined:
  - Adds mcycle/mcycleh (0xB00/0xB80) and minstret/minstreth (0xB02/0xB82), 64-bit, read/write.
  - mcycle increments every cycle.
  - minstret increments when instr_retire=1 and no CSR write targets it that cycle; a CSR write has priority over the increment.
  - Low-half carry into the high half occurs on the same edge (0xFFFF_FFFF → 0, high+1).
- ZICNTR_EN undefined: these addresses are unimplemented (csr_illegal=1) and no counter logic is built.

Test Plan:
- Reset release → read 0x305 = MTVEC_RESET, 0x300 = 0x0000_1800, redirect_valid=0, busy=0.
- mtvec=0x8000_0001, MIE=1, MEIE=1, irq_external=1:
  - Expect irq_req=1, irq_code=11.
  - Trap pulse (irq, code 11, pc 0x100) → next cycle redirect_pc = 0x8000_002C; mepc=0x100; mcause=0x8000_000B; MIE=0, MPIE=1.
- Exception code 2, pc 0x203, tval 0xDEAD_BEEF → mepc=0x200, mtval=0xDEAD_BEEF, redirect_pc = mtvec BASE.
- MRET after the trap above → 1-cycle redirect to mepc, MIE=1, MPIE=1.
- Same cycle trap_valid+mret_valid+CSR write to mscratch → trap sequence only, mscratch unchanged.
- Set 0x0000_0008 then clear 0x0000_0008 on mstatus toggles MIE. Write to 0x344 → csr_illegal=1, mip unchanged.
- With ZICNTR_EN: write mcycle=0xFFFF_FFFF → next cycle mcycle=0, mcycleh=1.
